fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
//  Sits directly upstream of load-use hazard detection.
//  Consumes that unit's hold outputs (1 = hazard, freeze) and the ID-stage branch/jump redirect.
//  Produces the IF/ID fields (instr, PC+4, valid) decoded in ID, plus stall/flush statistics.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  CNT_W      16             width of saturating stall/flush counters
// PORTS
//  clk_i             in   1      clock; all state updates on rising edge
//  rst_i             in   1      reset, synchronous, active-high
//  pc_hold_i         in   1      1 = hold PC this cycle (load-use stall)
//  ifid_hold_i       in   1      1 = hold IF/ID register this cycle
//  flush_i           in   1      1 = taken branch/jump resolved in ID; redirect + squash
//  target_i          in   32     redirect address, valid when flush_i=1
//  imem_data_i       in   32     instruction word at imem_addr_o (combinational read)
//  imem_addr_o       out  32     = pc_o (combinational)
//  pc_o              out  32     current fetch PC
//  ifid_instr_o      out  32     IF/ID instruction
//  ifid_pc4_o        out  32     IF/ID PC+4 of that instruction
//  ifid_valid_o      out  1      1 = IF/ID holds a real instruction, 0 = bubble
//  misalign_o        out  1      sticky: a redirect target had target_i[1:0]!=0
//  stall_cnt_o       out  CNT_W  cycles with pc_hold_i=1 and flush_i=0 (saturating)
//  flush_cnt_o       out  CNT_W  cycles with flush_i=1 (saturating)
// BEHAVIOUR
//  - Reset (rst_i=1 at edge; overrides every other input, including mid-stall/flush):
//    pc=RESET_PC, ifid_instr=NOP(32'h0), ifid_pc4=0, ifid_valid=0, misalign=0, counters=0.
//  - Priority per edge: rst_i > flush_i > hold > advance.
//  - flush_i=1: pc <= {target_i[31:2],2'b00}; IF/ID <= bubble (instr=0, pc4=0, valid=0),
//    regardless of pc_hold_i/ifid_hold_i; misalign <= misalign | (target_i[1:0]!=0).
//  - Otherwise PC: pc_hold_i=1 -> pc unchanged; else pc <= pc+4, modulo 2^32 (FFFF_FFFC -> 0).
//  - Otherwise IF/ID: ifid_hold_i=1 -> all three fields unchanged;
//    else {instr,pc4,valid} <= {imem_data_i, pc+4, 1}.
//  - Holds are independent. pc_hold=0 with ifid_hold=1 is legal: the fetched word is dropped.
//    pc_hold=1 with ifid_hold=0 is legal: the same PC is re-latched next edge.
//  - Latency: instruction at PC p appears on ifid_instr_o one edge after pc_o==p with no hold.
//  - Counters: +1 per qualifying edge; hold at 2^CNT_W-1, never wrap.
//    stall_cnt does not count a cycle in which flush_i=1.
//  - imem_addr_o/pc_o are register outputs; no combinational path from any input to any output.
// STRUCTURE
//  - Shared package pipeline_pkg: NOP_INSTR=32'h0, INSTR_W=32, PC_STEP=4, IFID bubble constant.
//  - One sub-module: sat_counter #(W) (clk, rst, inc, count), instantiated twice.
//  - Remainder (PC reg, next-PC mux, IF/ID reg) stays in this file.
// TESTING
//  1 Reset then 3 free-running cycles, imem returns 0x8C01_0004 / 0x0022_1820 / 0x0000_0000
//    -> pc_o 0,4,8,C; IF/ID pc4 4,8,C; valid=1 from first post-reset edge.
//  2 pc_hold=ifid_hold=1 for 2 cycles at pc=8
//    -> pc_o stays 8, IF/ID unchanged, stall_cnt=2; resumes pc=C after release.
//  3 flush_i=1, target=0x40 while pc_hold=1 -> pc=0x40, ifid_valid=0, instr=0, flush_cnt=1, stall_cnt not incremented.
//  4 flush with target=0x43 -> pc=0x40, misalign_o=1 and stays 1 until rst_i.
//  5 PC at 0xFFFF_FFFC, no hold -> pc wraps to 0, ifid_pc4_o=0.
//  6 rst_i asserted during hold+flush -> all outputs at reset values next edge.
//    Separately, CNT_W=2 with 5 stall cycles -> stall_cnt_o=3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the front-end stages.
package pipeline_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
        logic               valid;
    } ifid_t;

    // An empty IF/ID slot: NOP word, zero PC+4, not valid.
    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts qualifying cycles and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // Next count: step only when enabled and not already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID register and
// stall/flush statistics. Redirect beats hold; holds on PC and IF/ID are independent.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pc_hold_i,
    input  logic             ifid_hold_i,
    input  logic             flush_i,
    input  logic [31:0]      target_i,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    logic        misalign_q, misalign_d;
    logic        stall_inc;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + PC_STEP;

    // Next PC, IF/ID contents and misalign flag: redirect first, then holds, else advance.
    always_comb begin
        pc_d       = pc_q;
        ifid_d     = ifid_q;
        misalign_d = misalign_q;
        if (flush_i) begin
            pc_d       = {target_i[31:2], 2'b00};
            ifid_d     = IFID_BUBBLE;
            misalign_d = misalign_q | (|target_i[1:0]);
        end else begin
            if (!pc_hold_i) begin
                pc_d = pc_plus4;
            end
            if (!ifid_hold_i) begin
                ifid_d = '{instr: imem_data_i, pc4: pc_plus4, valid: 1'b1};
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            ifid_q     <= IFID_BUBBLE;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ifid_q     <= ifid_d;
            misalign_q <= misalign_d;
        end
    end

    // A redirect cycle is charged to flushes only, never to stalls.
    assign stall_inc = pc_hold_i & ~flush_i;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (stall_inc),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (flush_i),
        .count (flush_cnt_o)
    );

    assign pc_o         = pc_q;
    assign imem_addr_o  = pc_q;
    assign ifid_instr_o = ifid_q.instr;
    assign ifid_pc4_o   = ifid_q.pc4;
    assign ifid_valid_o = ifid_q.valid;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a reference model pushes expected post-edge state
// into a queue as each cycle is driven; each test pops and compares.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i, pc_hold_i, ifid_hold_i, flush_i;
    logic [31:0] target_i, imem_data_i;
    logic [31:0] imem_addr_o, pc_o, ifid_instr_o, ifid_pc4_o;
    logic        ifid_valid_o, misalign_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    // Narrow-counter instance sharing the same stimulus.
    logic [31:0] s_addr, s_pc, s_instr, s_pc4;
    logic        s_valid, s_mis;
    logic [1:0]  s_stall, s_flush;
    logic [31:0] s_imem;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h8C01_0004;
            32'h4: return 32'h0022_1820;
            32'h8: return 32'h0000_0000;
            default: return a ^ 32'h5A5A_0003;
        endcase
    endfunction

    assign imem_data_i = mem_word(imem_addr_o);
    assign s_imem      = mem_word(s_addr);

    fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_hold_i(pc_hold_i), .ifid_hold_i(ifid_hold_i),
        .flush_i(flush_i), .target_i(target_i), .imem_data_i(imem_data_i),
        .imem_addr_o(imem_addr_o), .pc_o(pc_o), .ifid_instr_o(ifid_instr_o),
        .ifid_pc4_o(ifid_pc4_o), .ifid_valid_o(ifid_valid_o), .misalign_o(misalign_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    fetch_stage #(.RESET_PC(32'h0), .CNT_W(2)) dut_small (
        .clk_i(clk_i), .rst_i(rst_i), .pc_hold_i(pc_hold_i), .ifid_hold_i(ifid_hold_i),
        .flush_i(flush_i), .target_i(target_i), .imem_data_i(s_imem),
        .imem_addr_o(s_addr), .pc_o(s_pc), .ifid_instr_o(s_instr),
        .ifid_pc4_o(s_pc4), .ifid_valid_o(s_valid), .misalign_o(s_mis),
        .stall_cnt_o(s_stall), .flush_cnt_o(s_flush)
    );

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_mis;
    logic [15:0] m_stall, m_flush;
    logic [1:0]  m_stall_s;

    logic [163:0] sbq[$];
    logic [163:0] exp_v;
    int compared   = 0;
    int mismatched = 0;

    function automatic logic [163:0] snap();
        return {imem_addr_o, pc_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o,
                misalign_o, stall_cnt_o, flush_cnt_o, s_stall};
    endfunction

    task automatic drive(input logic r, input logic ph, input logic ih,
                         input logic fl, input logic [31:0] t);
        rst_i = r; pc_hold_i = ph; ifid_hold_i = ih; flush_i = fl; target_i = t;
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
            m_stall = 16'h0; m_flush = 16'h0; m_stall_s = 2'd0;
        end else if (fl) begin
            m_pc = {t[31:2], 2'b00}; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            if (t[1:0] != 2'b00) m_mis = 1'b1;
            if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end else begin
            if (!ih) begin
                m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end
            if (ph) begin
                if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
                if (m_stall_s != 2'd3) m_stall_s = m_stall_s + 2'd1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        sbq.push_back({m_pc, m_pc, m_instr, m_pc4, m_valid, m_mis, m_stall, m_flush, m_stall_s});
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        sbq.delete();
        drive(1, 1, 1, 1, 32'h44);
        exp_v = sbq.pop_front(); compared++;
        if (snap() !== exp_v) begin
            mismatched++; $display("FAIL reset: got %h want %h", snap(), exp_v);
        end
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 32'h0);
            exp_v = sbq.pop_front(); compared++;
            if (snap() !== exp_v) begin
                mismatched++; $display("FAIL free_run[%0d]: got %h want %h", i, snap(), exp_v);
            end
        end
    endtask

    task automatic test_hold();
        drive(1, 0, 0, 0, 32'h0);
        void'(sbq.pop_front());
        for (int i = 0; i < 5; i++) begin
            // two advances to pc=8, two full holds, then release to pc=C
            drive(0, (i == 2 || i == 3), (i == 2 || i == 3), 0, 32'h0);
            exp_v = sbq.pop_front(); compared++;
            if (snap() !== exp_v) begin
                mismatched++; $display("FAIL hold[%0d]: got %h want %h", i, snap(), exp_v);
            end
        end
        compared++;
        if (stall_cnt_o !== 16'd2 || pc_o !== 32'hC) begin
            mismatched++;
            $display("FAIL hold_end: stall=%0d pc=%h want stall=2 pc=c", stall_cnt_o, pc_o);
        end
    endtask

    task automatic test_flush_stalled();
        drive(0, 1, 0, 1, 32'h40);
        exp_v = sbq.pop_front(); compared++;
        if (snap() !== exp_v || pc_o !== 32'h40 || ifid_valid_o !== 1'b0 || flush_cnt_o !== 16'd1) begin
            mismatched++; $display("FAIL flush_stalled: got %h want %h", snap(), exp_v);
        end
        drive(0, 0, 0, 0, 32'h0);
        exp_v = sbq.pop_front(); compared++;
        if (snap() !== exp_v) begin
            mismatched++; $display("FAIL flush_resume: got %h want %h", snap(), exp_v);
        end
    endtask

    task automatic test_misalign();
        drive(0, 0, 0, 1, 32'h43);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(0, 0, 0, (i == 2), 32'h100);
            exp_v = sbq.pop_front(); compared++;
            if (snap() !== exp_v || misalign_o !== 1'b1) begin
                mismatched++; $display("FAIL misalign[%0d]: got %h want %h", i, snap(), exp_v);
            end
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 32'h0);
        void'(sbq.pop_front());
        exp_v = sbq.pop_front(); compared++;
        if (snap() !== exp_v || pc_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin
            mismatched++; $display("FAIL wrap: got %h want %h", snap(), exp_v);
        end
    endtask

    task automatic test_split_holds();
        for (int i = 0; i < 24; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), $urandom & 32'hFFFF_FFFC);
            exp_v = sbq.pop_front(); compared++;
            if (snap() !== exp_v) begin
                mismatched++; $display("FAIL split_holds[%0d]: got %h want %h", i, snap(), exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 1, 32'h81);
        drive(0, 1, 1, 0, 32'h0);
        void'(sbq.pop_front()); void'(sbq.pop_front());
        drive(1, 1, 1, 1, 32'h83);
        exp_v = sbq.pop_front(); compared++;
        if (snap() !== exp_v || misalign_o !== 1'b0) begin
            mismatched++; $display("FAIL reset_mid: got %h want %h", snap(), exp_v);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 32'h0);
            exp_v = sbq.pop_front(); compared++;
            if (snap() !== exp_v) begin
                mismatched++; $display("FAIL saturation[%0d]: got %h want %h", i, snap(), exp_v);
            end
        end
        compared++;
        if (s_stall !== 2'd3 || stall_cnt_o !== 16'd5) begin
            mismatched++;
            $display("FAIL saturation_end: small=%0d wide=%0d want 3 and 5", s_stall, stall_cnt_o);
        end
    endtask

    initial begin
        rst_i = 1'b1; pc_hold_i = 1'b0; ifid_hold_i = 1'b0; flush_i = 1'b0; target_i = 32'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
        m_stall = 16'h0; m_flush = 16'h0; m_stall_s = 2'd0;
        #1;
        test_reset();
        test_free_run();
        test_hold();
        test_flush_stalled();
        test_misalign();
        test_wrap();
        test_split_holds();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
